rom_fetch_ctrl: RTL

Instruction-fetch sequencer between the CPU core and the 256x8 program ROM, which has a 1-cycle synchronous read. Owns the program counter, issues ROM addresses, and captures returned bytes into a held output register. Handles sequential fetch, jumps, and two interrupt sources. Interrupt entry reads a vector byte from fixed ROM locations, and a single-level saved return address is restored on return.

---
 rtl/rom_fetch_ctrl_pkg.sv | 22 ++
 rtl/rom_fetch_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl_pkg.sv
// rom_fetch_pkg
//   Shared definitions for the instruction-fetch sequencer:
//   fetch FSM state encoding, default interrupt vector locations
//   and the bit positions of the two interrupt sources.
package rom_fetch_pkg;

    typedef enum logic [2:0] {
        S_ADDR,   // ROM samples ROM_ADDR on the closing edge
        S_CAPT,   // returned byte captured into DATA_OUT/PC_OUT
        S_READY,  // DATA_VALID, waiting for a request
        S_VADDR,  // ROM samples the interrupt vector address
        S_VCAPT   // vector byte loaded into PC
    } fetch_state_t;

    localparam logic [7:0] ROM_MOUSE_VEC = 8'hFF;
    localparam logic [7:0] ROM_TIMER_VEC = 8'hFE;

    localparam int unsigned IRQ_W         = 2;
    localparam int unsigned IRQ_MOUSE_BIT = 0;
    localparam int unsigned IRQ_TIMER_BIT = 1;

endpackage

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl
//   Instruction-fetch sequencer between the CPU core and a 256x8
//   synchronous-read program ROM. Owns the PC, issues ROM addresses,
//   captures returned bytes, and handles jumps, returns and two
//   interrupt sources with a single-level saved return address.
//
// Ports
//   CLK        system clock (all state on posedge)
//   RESET      synchronous, active-high reset
//   ROM_ADDR   registered ROM address
//   ROM_DATA   ROM read data, one cycle after ROM_ADDR is sampled
//   NEXT_REQ   fetch byte at PC+1
//   JUMP_REQ   fetch byte at JUMP_ADDR
//   JUMP_ADDR  jump target
//   RETURN_REQ fetch byte at saved return address, leave ISR
//   IRQ        level requests: bit0 mouse, bit1 timer
//   IRQ_ACK    one-cycle pulse when the matching vector fetch starts
//   DATA_OUT   captured instruction/operand byte
//   PC_OUT     address of the byte in DATA_OUT
//   DATA_VALID DATA_OUT/PC_OUT valid, controller waiting for a request
//   BUSY       inverse of DATA_VALID; requests ignored while high
module rom_fetch_ctrl
    import rom_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        DATA_W    = 8,
    parameter logic [ADDR_W-1:0]  MOUSE_VEC = ROM_MOUSE_VEC,
    parameter logic [ADDR_W-1:0]  TIMER_VEC = ROM_TIMER_VEC
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_DATA,
    input  logic              NEXT_REQ,
    input  logic              JUMP_REQ,
    input  logic [ADDR_W-1:0] JUMP_ADDR,
    input  logic              RETURN_REQ,
    input  logic [IRQ_W-1:0]  IRQ,
    output logic [IRQ_W-1:0]  IRQ_ACK,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              DATA_VALID,
    output logic              BUSY
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_nxt;
    logic [ADDR_W-1:0] saved_ret, saved_nxt;
    logic              in_isr, in_isr_nxt;
    logic [IRQ_W-1:0]  ack_q, ack_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [ADDR_W-1:0] pcout_q, pcout_nxt;

    logic              req_any;
    logic              irq_open;
    logic [ADDR_W-1:0] target;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_ADDR;
            pc         <= '0;
            rom_addr_q <= '0;
            saved_ret  <= '0;
            in_isr     <= 1'b0;
            ack_q      <= '0;
            data_q     <= '0;
            pcout_q    <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            rom_addr_q <= rom_addr_nxt;
            saved_ret  <= saved_nxt;
            in_isr     <= in_isr_nxt;
            ack_q      <= ack_nxt;
            data_q     <= data_nxt;
            pcout_q    <= pcout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        rom_addr_nxt = rom_addr_q;
        saved_nxt    = saved_ret;
        in_isr_nxt   = in_isr;
        ack_nxt      = '0;
        data_nxt     = data_q;
        pcout_nxt    = pcout_q;

        req_any = NEXT_REQ | JUMP_REQ | RETURN_REQ;
        // RETURN leaves the ISR in the same accept cycle, so a pending
        // IRQ can be taken immediately on that return.
        irq_open = RETURN_REQ | ~in_isr;

        if (RETURN_REQ)
            target = saved_ret;
        else if (JUMP_REQ)
            target = JUMP_ADDR;
        else
            target = pc + ADDR_W'(1);

        case (state)
            S_ADDR: state_nxt = S_CAPT;

            S_CAPT: begin
                data_nxt  = ROM_DATA;
                pcout_nxt = pc;
                state_nxt = S_READY;
            end

            S_READY: begin
                if (req_any) begin
                    if (RETURN_REQ)
                        in_isr_nxt = 1'b0;
                    if (irq_open && (IRQ != '0)) begin
                        saved_nxt  = target;
                        in_isr_nxt = 1'b1;
                        state_nxt  = S_VADDR;
                        if (IRQ[IRQ_MOUSE_BIT]) begin
                            rom_addr_nxt           = MOUSE_VEC;
                            ack_nxt[IRQ_MOUSE_BIT] = 1'b1;
                        end else begin
                            rom_addr_nxt           = TIMER_VEC;
                            ack_nxt[IRQ_TIMER_BIT] = 1'b1;
                        end
                    end else begin
                        pc_nxt       = target;
                        rom_addr_nxt = target;
                        state_nxt    = S_ADDR;
                    end
                end
            end

            S_VADDR: state_nxt = S_VCAPT;

            S_VCAPT: begin
                pc_nxt       = ADDR_W'(ROM_DATA);
                rom_addr_nxt = ADDR_W'(ROM_DATA);
                state_nxt    = S_ADDR;
            end

            default: state_nxt = S_ADDR;
        endcase
    end

    assign ROM_ADDR   = rom_addr_q;
    assign IRQ_ACK    = ack_q;
    assign DATA_OUT   = data_q;
    assign PC_OUT     = pcout_q;
    assign DATA_VALID = (state == S_READY);
    assign BUSY       = ~DATA_VALID;

endmodule
